// File: rtl/fifo_read_checker.sv
// Read-side checker: drains the AFIFO after a start delay and compares against an incrementing sequence.
// Optional FIFO_READ_CHECKER_RESYNC_EN: on a mismatch, re-seed the expected value from the received word.
module fifo_read_checker #(
  parameter int              Width      = 16,
  parameter logic [Width-1:0] Seed      = '0,
  parameter int              StartDelay = 1023
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  output logic             r,
  input  logic [Width-1:0] rd,
  input  logic             rok,
  output logic [31:0]      wordCount,
  output logic [15:0]      errCount,
  output logic [Width-1:0] firstErrExp,
  output logic [Width-1:0] firstErrGot,
  output logic [3:0]       led
);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Delay = 2'd1,
    Run   = 2'd2
  } state_t;

  localparam logic [31:0] DelayLast = 32'(StartDelay - 1);

  state_t           state;
  state_t           nextState;
  logic [31:0]      delayCnt;
  logic [Width-1:0] expVal;
  logic [Width-1:0] expNext;
  logic             xfer;
  logic             mismatch;
  logic             ledWord;
  logic             ledErr;
  logic             ledSat;
  logic             inRun;

  always_ff @(posedge clk) begin
    if (!rst_) state <= Idle;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      Idle:    if (en) nextState = (StartDelay == 0) ? Run : Delay;
      Delay: begin
        if (!en)                        nextState = Idle;
        else if (delayCnt == DelayLast) nextState = Run;
      end
      Run:     if (!en) nextState = Idle;
      default: nextState = Idle;
    endcase
  end

  // r is a decode of the state flop, so it changes only on clock edges.
  always_comb begin
    inRun = (state == Run);
    r     = inRun;
  end

  // Leaving DELAY (to IDLE or RUN) clears the counter so every entry waits the full delay.
  always_ff @(posedge clk) begin
    if (!rst_)               delayCnt <= '0;
    else if (state == Delay) delayCnt <= delayCnt + 32'd1;
    else                     delayCnt <= '0;
  end

  assign xfer     = r & rok;
  assign mismatch = xfer & (rd != expVal);

`ifdef FIFO_READ_CHECKER_RESYNC_EN
  assign expNext = mismatch ? (rd + Width'(1)) : (expVal + Width'(1));
`else
  assign expNext = expVal + Width'(1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_) begin
      expVal      <= Seed;
      wordCount   <= '0;
      errCount    <= '0;
      firstErrExp <= '0;
      firstErrGot <= '0;
    end else begin
      if (xfer) begin
        expVal <= expNext;
        if (wordCount != '1) wordCount <= wordCount + 32'd1;
      end
      if (mismatch) begin
        if (errCount != '1) errCount <= errCount + 16'd1;
        if (errCount == '0) begin
          firstErrExp <= expVal;
          firstErrGot <= rd;
        end
      end
    end
  end

  // Sticky status follows the registered counts, so it lags a transfer by one edge.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      ledWord <= 1'b0;
      ledErr  <= 1'b0;
      ledSat  <= 1'b0;
    end else begin
      if (wordCount != '0) ledWord <= 1'b1;
      if (errCount != '0)  ledErr  <= 1'b1;
      if (&errCount)       ledSat  <= 1'b1;
    end
  end

  assign led = {ledSat, ledErr, ledWord, inRun};

endmodule
